// File: rtl/ov7670_capture_scaled.sv
// ov7670_capture_scaled: OV7670 byte-pair capture with X/Y decimation into a linear frame-buffer write stream,
// plus frame arming, a frame-done pulse and line/frame geometry checking.
module ov7670_capture_scaled #(
  parameter int IN_WIDTH  = 640,
  parameter int IN_HEIGHT = 480,
  parameter int X_DECIM   = 2,
  parameter int Y_DECIM   = 2,
  parameter int PIX_FMT   = 0,
  parameter int ADDR_W    = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       pixel,
  output logic              we,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);
  localparam int XW   = $clog2(IN_WIDTH + 2);
  localparam int YW   = $clog2(IN_HEIGHT + 2);
  localparam int LAST = (IN_WIDTH / X_DECIM) * (IN_HEIGHT / Y_DECIM) - 1;

  typedef enum logic [1:0] {WAIT_SYNC, BLANK, ACTIVE} state_t;
  state_t state;

  logic          vsync_q, href_q, armed, phase, line_err;
  logic [7:0]    byte0;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [2:0]    xd, yd;
  logic          v_rise, v_fall, h_rise, h_fall, keep;
  logic [15:0]   pix_next;

  assign v_rise   = vsync & ~vsync_q;
  assign v_fall   = ~vsync & vsync_q;
  assign h_rise   = href & ~href_q;
  assign h_fall   = ~href & href_q;
  assign keep     = armed && xd == 3'd0 && yd == 3'd0 && x_cnt < XW'(IN_WIDTH) && y_cnt < YW'(IN_HEIGHT);
  assign pix_next = PIX_FMT == 1 ? {byte0, d} : {4'b0, byte0[3:0], d};

  // x/y counters saturate one past the nominal size so oversize geometry still reads as an error
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_SYNC;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      armed      <= 1'b0;
      phase      <= 1'b0;
      line_err   <= 1'b0;
      byte0      <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      xd         <= '0;
      yd         <= '0;
      addr       <= '0;
      pixel      <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      href_q     <= href;
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (we && addr != ADDR_W'(LAST)) addr <= addr + ADDR_W'(1);
      case (state)
        WAIT_SYNC: if (vsync) state <= BLANK;
        BLANK: if (v_fall) begin
          state    <= ACTIVE;
          armed    <= capture_en;
          busy     <= capture_en;
          addr     <= '0;
          phase    <= 1'b0;
          x_cnt    <= '0;
          y_cnt    <= '0;
          xd       <= '0;
          yd       <= '0;
          line_err <= 1'b0;
        end
        ACTIVE: if (v_rise) begin
          state <= BLANK;
          busy  <= 1'b0;
          armed <= 1'b0;
          if (armed) begin
            frame_done <= 1'b1;
            frame_err  <= line_err | href_q | (y_cnt != YW'(IN_HEIGHT));
          end
        end else if (href) begin
          if (h_rise) begin
            byte0 <= d;
            phase <= 1'b1;
            x_cnt <= '0;
            xd    <= '0;
          end else if (!phase) begin
            byte0 <= d;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            we    <= keep;
            if (keep) pixel <= pix_next;
            if (x_cnt != XW'(IN_WIDTH + 1)) x_cnt <= x_cnt + XW'(1);
            xd <= xd == 3'(X_DECIM - 1) ? 3'd0 : xd + 3'd1;
          end
        end else if (h_fall) begin
          phase    <= 1'b0;
          line_err <= line_err | phase | (x_cnt != XW'(IN_WIDTH));
          if (y_cnt != YW'(IN_HEIGHT + 1)) y_cnt <= y_cnt + YW'(1);
          yd <= yd == 3'(Y_DECIM - 1) ? 3'd0 : yd + 3'd1;
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end
endmodule

// File: doc/ov7670_capture_scaled.md
Name: ov7670_capture_scaled

Overview:
- Parametrised OV7670 capture front end: takes camera pclk/vsync/href/d, assembles RGB444 or RGB565 pixels and decimates by configurable X/Y factors.
- Produces a linear frame-buffer write stream (addr/pixel/we) into BRAM.
- Adds frame arming, a frame-done pulse and geometry error detection.
- Sits between the camera pins and the dual-port frame buffer feeding the convolution pipeline.

Parameters:
- IN_WIDTH, 640: active pixels per line expected from the camera.
- IN_HEIGHT, 480: active lines per frame expected.
- X_DECIM, 2: keep 1 of every X_DECIM pixels per line (1..8).
- Y_DECIM, 2: keep 1 of every Y_DECIM lines (1..8).
- PIX_FMT, 0: 0 = RGB444 (byte0 XXXXRRRR, byte1 GGGGBBBB); 1 = RGB565 (byte0 RRRRRGGG, byte1 GGGBBBBB).
- ADDR_W, 17: write address width; must satisfy 2^ADDR_W >= (IN_WIDTH/X_DECIM)*(IN_HEIGHT/Y_DECIM).

Ports:
- pclk  in  1: camera pixel clock; all logic is on its rising edge.
- reset_n  in  1: asynchronous active-low reset.
- vsync  in  1: frame sync, high between frames.
- href  in  1: line valid.
- d  in  8: camera data byte.
- capture_en  in  1: arm request, sampled at vsync falling edge.
- addr  out  ADDR_W: frame-buffer write address.
- pixel  out  16: RGB444 as {4'b0,R4,G4,B4}; RGB565 as {R5,G6,B5}.
- we  out  1: write strobe, one pclk per kept pixel.
- frame_done  out  1: one-cycle pulse at the end of an armed frame.
- frame_err  out  1: geometry status of the last completed frame, held until the next frame_done.
- busy  out  1: high while an armed frame is in progress.

Behaviour:
- Reset values: addr 0, pixel 0, we 0, frame_done 0, frame_err 0, busy 0, state WAIT_SYNC.
- Edge detection uses registered vsync_q and href_q; an edge is the current input differing from its _q copy.
- FSM states and transitions:
  - WAIT_SYNC: ignores data; on vsync high goes to BLANK. This prevents capturing a partial first frame after reset.
  - BLANK: on vsync fall, goes to ACTIVE. Sets armed = capture_en, busy = armed. Clears addr, byte phase, x/y counters and the line-error flag.
  - ACTIVE: captures data.
    - On vsync rise, returns to BLANK.
    - If armed, asserts frame_done for 1 cycle and updates frame_err.
    - busy drops on the same edge.
- Byte phase:
  - Toggles on each pclk with href high; resets to 0 on href rise.
  - Phase 0 latches byte0. Phase 1 completes the pixel and increments x_cnt.
- Line accounting:
  - On href fall: y_cnt increments. The line-error flag is set if x_cnt != IN_WIDTH or phase == 1 (odd byte count; the dangling byte is discarded).
  - On href rise: x_cnt is cleared.
- Pixel keep rule:
  - Uses wrap counters xd (0..X_DECIM-1) and yd (0..Y_DECIM-1), not modulo arithmetic.
  - A pixel is kept iff armed, xd == 0, yd == 0, x_cnt < IN_WIDTH and y_cnt < IN_HEIGHT.
  - Excess pixels and lines are dropped, never written.
- Write timing and addressing:
  - pixel and we are registered: we is high in the cycle after the phase-1 pclk edge. addr holds that pixel's address.
  - addr increments the cycle after each we.
  - addr saturates at (IN_WIDTH/X_DECIM)*(IN_HEIGHT/Y_DECIM)-1 and never wraps.
- frame_err at frame end = line-error flag OR y_cnt != IN_HEIGHT. An unarmed frame leaves frame_err unchanged.
- vsync rising mid-line: treated as frame end. The current line is counted short, so frame_err = 1.
- capture_en changing during ACTIVE: no effect until the next vsync fall.
- Asynchronous reset mid-frame: all outputs clear immediately. The block resumes in WAIT_SYNC and needs a full vsync cycle before capturing.

Test Plan:
- IN_WIDTH=8, IN_HEIGHT=4, decim 2x2, RGB444, capture_en=1; one clean frame with byte0=0x0A, byte1=0xBC per pixel -> 8 we pulses, addr 0..7, pixel 0x0ABC, one frame_done, frame_err=0.
- Same config with RGB565, bytes 0xF8 then 0x1F -> pixel 0xF81F; decim 1x1 -> 32 writes, addr 0..31.
- Reset released mid-frame (vsync low, href toggling) -> no we until after the next vsync high→low; first written addr is 0.
- capture_en=0 at vsync fall -> zero we, no frame_done, busy=0; next frame with capture_en=1 is captured normally.
- One line of 7 pixels (14 bytes) and one line with 15 bytes -> frame_err=1 at frame_done. A following clean frame -> frame_err=0.
- Camera sends 6 lines of 10 pixels against 4x8 params -> no writes beyond addr 7, addr holds at 7, frame_err=1.
